key_debounce: RTL and testbench
===============================

// Module: key_debounce
// PURPOSE
//  Conditions one raw mechanical key/switch input into a clean, glitch-free level.
//  Drives the A input of the downstream control FSM (IDEL/START/STOP/CLEAR), plus press/release strobes.
//  Pipeline: 2-FF synchroniser, then a 4-state debounce FSM with a stability counter.
// PARAMETERS
//  CNT_MAX    1_000_000  cycles an input change must stay stable before it is accepted (>=2; 20 ms @ 50 MHz)
//  KEY_ACTIVE 1'b0       raw pin level that means "pressed" (0 = active-low board key)
//  LONG_MAX   50_000_000 cycles held after acceptance before key_long fires (used only with KEY_LONGPRESS_EN)
// PORTS
//  clk         input  1  system clock; one clock domain
//  rst_n       input  1  asynchronous, active-low reset
//  key_in      input  1  raw key pin; asynchronous to clk; bouncy
//  key_level   output 1  debounced level, 1 = pressed; feeds downstream FSM input A
//  key_press   output 1  1-cycle pulse, same edge key_level rises
//  key_release output 1  1-cycle pulse, same edge key_level falls
//  key_long    output 1  1-cycle long-press pulse (tied 0 without KEY_LONGPRESS_EN)
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - sync FFs load ~KEY_ACTIVE (released level).
//   - state=UP, counters=0.
//   - key_level, key_press, key_release, key_long all 0.
//  Input path:
//   - key_s = sync2 ^ ~KEY_ACTIVE (normalised, 1 = pressed).
//   - key_in must never feed logic other than sync1.
//  Counter: cnt, width $clog2(CNT_MAX); cleared on every state change; never wraps.
//  States / transitions (all outputs registered):
//   UP:        key_s=1 -> DN_FILT (cnt=0); else stay.
//   DN_FILT:   key_s=0 -> UP (bounce, no output change).
//              key_s=1 & cnt==CNT_MAX-1 -> DOWN, key_level<=1, key_press<=1.
//              else cnt++.
//   DOWN:      key_s=0 -> UP_FILT (cnt=0); else stay.
//   UP_FILT:   key_s=1 -> DOWN (bounce).
//              key_s=0 & cnt==CNT_MAX-1 -> UP, key_level<=0, key_release<=1.
//              else cnt++.
//   Unreachable encodings -> UP.
//  Latency:
//   - Raw change set up before edge 1 and stable thereafter -> key_level changes at edge 3+CNT_MAX
//     (2 sync + 1 detect + CNT_MAX filter).
//   - Any opposite sample in a FILT state restarts the full filter from zero.
//  Pulses: key_press/key_release high exactly 1 cycle; never both high; never high in the same cycle as reset release.
//  Glitches shorter than CNT_MAX cycles never reach key_level.
//  Reset mid-filter: discards progress; key_level=0 even if key physically held; re-qualifies from UP after release.
// CONFIGURATION
//  KEY_LONGPRESS_EN defined:
//   - lcnt ($clog2(LONG_MAX) bits) counts cycles in DOWN, starting at 0 on entry.
//   - At lcnt==LONG_MAX-1: key_long pulses 1 cycle and lcnt saturates (one pulse per press).
//   - Leaving DOWN or reset clears lcnt.
//   - Bounce back to DOWN from UP_FILT keeps lcnt (held continuously).
//  KEY_LONGPRESS_EN undefined:
//   - No lcnt logic; key_long driven constant 0.
//   - All other behaviour identical.
// TESTING (CNT_MAX=4, KEY_ACTIVE=0, LONG_MAX=8)
//  1 Reset, key_in=1 -> all outputs 0; key_in 1->0 before edge 1 -> key_level=1 and key_press=1 at edge 7, key_press 0 at edge 8.
//  2 Pressed, key_in 0->1 held -> key_level=0 and key_release=1 at edge 7 after change; single pulse.
//  3 Bounce: key_in low 3 cycles, high 1, low steady -> no key_press until 4 stable cycles after last edge; exactly one pulse.
//  4 Glitch: key_in low for 1,2,3 cycles each -> key_level stays 0, no pulses.
//  5 Reset asserted mid-DN_FILT (cnt=2), released, key still low -> outputs 0 during reset; key_press exactly 4 cycles after the 3-cycle pipeline refills.
//  6 KEY_LONGPRESS_EN: hold 20 cycles after key_press -> key_long=1 once, 8 cycles after key_press; without macro key_long=0 throughout.

Source files
------------

// File: rtl/key_debounce.sv
// Debounces one raw key input: a 2-FF synchroniser feeds a 4-state filter FSM that drives a clean level and press/release strobes.
// Optional long-press strobe is built only when KEY_LONGPRESS_EN is defined; otherwise key_long is tied low.
module key_debounce #(
    parameter int   CNT_MAX    = 1_000_000,
    parameter logic KEY_ACTIVE = 1'b0,
    parameter int   LONG_MAX   = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_in,
    output logic       key_level,
    output logic       key_press,
    output logic       key_release,
    output logic       key_long,
    output logic [1:0] dbg_state
);

    localparam int            CW       = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

    typedef enum logic [1:0] {
        UP      = 2'd0,
        DN_FILT = 2'd1,
        DOWN    = 2'd2,
        UP_FILT = 2'd3
    } state_t;

    logic          sync1;
    logic          sync2;
    logic          key_s;
    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          level_nx;
    logic          press_nx;
    logic          release_nx;

    // key_in is asynchronous and goes nowhere except sync1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= ~KEY_ACTIVE;
            sync2 <= ~KEY_ACTIVE;
        end else begin
            sync1 <= key_in;
            sync2 <= sync1;
        end
    end

    assign key_s     = sync2 ^ ~KEY_ACTIVE;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= UP;
            cnt         <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            key_level   <= level_nx;
            key_press   <= press_nx;
            key_release <= release_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        level_nx   = key_level;
        press_nx   = 1'b0;
        release_nx = 1'b0;
        case (state)
            UP: begin
                if (key_s) begin
                    state_nx = DN_FILT;
                    cnt_nx   = '0;
                end
            end
            DN_FILT: begin
                if (!key_s) begin
                    state_nx = UP;
                    cnt_nx   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nx = DOWN;
                    cnt_nx   = '0;
                    level_nx = 1'b1;
                    press_nx = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            DOWN: begin
                if (!key_s) begin
                    state_nx = UP_FILT;
                    cnt_nx   = '0;
                end
            end
            UP_FILT: begin
                if (key_s) begin
                    state_nx = DOWN;
                    cnt_nx   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nx   = UP;
                    cnt_nx     = '0;
                    level_nx   = 1'b0;
                    release_nx = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                state_nx = UP;
                cnt_nx   = '0;
            end
        endcase
    end

`ifdef KEY_LONGPRESS_EN
    localparam int            LW        = (LONG_MAX > 1) ? $clog2(LONG_MAX) : 1;
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_MAX - 1);

    logic [LW-1:0] lcnt;
    logic          long_done;

    // A bounce through UP_FILT back to DOWN keeps lcnt: the key never left.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lcnt      <= '0;
            long_done <= 1'b0;
            key_long  <= 1'b0;
        end else begin
            key_long <= 1'b0;
            if ((state == DN_FILT && state_nx == DOWN) || state_nx == UP) begin
                lcnt      <= '0;
                long_done <= 1'b0;
            end else if (state == DOWN) begin
                if (lcnt == LONG_LAST) begin
                    if (!long_done) begin
                        key_long  <= 1'b1;
                        long_done <= 1'b1;
                    end
                end else begin
                    lcnt <= lcnt + 1'b1;
                end
            end
        end
    end
`else
    // Folds to constant 0; LONG_MAX only matters for the long-press build.
    assign key_long = 1'b0 & (LONG_MAX > 0);
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed scenarios with literal expectations plus randomized key activity
// checked every cycle against a run-length model of the debounce rules.
module tb_key_debounce;

    localparam int   CNT_MAX    = 4;
    localparam logic KEY_ACTIVE = 1'b0;
    localparam int   LONG_MAX   = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_in = 1'b1;
    logic       key_level;
    logic       key_press;
    logic       key_release;
    logic       key_long;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;

    key_debounce #(
        .CNT_MAX   (CNT_MAX),
        .KEY_ACTIVE(KEY_ACTIVE),
        .LONG_MAX  (LONG_MAX)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_in     (key_in),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .key_long   (key_long),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // one active edge, then park on the falling edge where outputs are sampled and inputs driven
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Model: key_s is key_in two edges late; level flips once CNT_MAX+1 consecutive
    // detection edges disagree with it; any agreeing edge restarts the count.
    logic m_p0 = 1'b0, m_p1 = 1'b0, m_lvl = 1'b0;
    logic m_press = 1'b0, m_rel = 1'b0, m_long = 1'b0, m_ldone = 1'b0;
    int   m_run = 0, m_lc = 0;

    always @(posedge clk or negedge rst_n) begin : model
        logic ks, lv, pr, rl, lg, ld;
        int   rn, lc;
        if (!rst_n) begin
            m_p0 <= 1'b0; m_p1 <= 1'b0; m_lvl <= 1'b0; m_run <= 0;
            m_press <= 1'b0; m_rel <= 1'b0; m_long <= 1'b0; m_lc <= 0; m_ldone <= 1'b0;
        end else begin
            ks = m_p1; lv = m_lvl; rn = m_run; lc = m_lc; ld = m_ldone;
            pr = 1'b0; rl = 1'b0; lg = 1'b0;
`ifdef KEY_LONGPRESS_EN
            // cycles spent settled in the pressed state
            if (lv && rn == 0) begin
                if (lc == LONG_MAX - 1) begin
                    if (!ld) begin
                        lg = 1'b1;
                        ld = 1'b1;
                    end
                end else begin
                    lc++;
                end
            end
`endif
            rn = (ks != lv) ? rn + 1 : 0;
            if (rn == CNT_MAX + 1) begin
                lv = ~lv; rn = 0; lc = 0; ld = 1'b0;
                pr = lv; rl = ~lv;
            end
            m_p1 <= m_p0;
            m_p0 <= (key_in == KEY_ACTIVE);
            m_lvl <= lv; m_run <= rn; m_lc <= lc; m_ldone <= ld;
            m_press <= pr; m_rel <= rl; m_long <= lg;
        end
    end

    // scoreboard: every cycle, DUT against model
    always @(negedge clk) begin
        chk("level_vs_model", key_level, m_lvl);
        chk("press_vs_model", key_press, m_press);
        chk("release_vs_model", key_release, m_rel);
        chk("long_vs_model", key_long, m_long);
        chk("press_release_exclusive", key_press & key_release, 0);
    end

    int presses;
    int hold;

    initial begin
        // 1: reset with key released, then press just before edge 1
        key_in = 1'b1;
        rst_n  = 1'b0;
        repeat (3) tick();
        chk("reset_level", key_level, 0);
        chk("reset_press", key_press, 0);
        chk("reset_release", key_release, 0);
        chk("reset_long", key_long, 0);
        rst_n  = 1'b1;
        key_in = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("t1_level", key_level, (k >= 7) ? 1 : 0);
            chk("t1_press", key_press, (k == 7) ? 1 : 0);
        end

        // 2: release while pressed
        key_in = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk("t2_level", key_level, (k < 7) ? 1 : 0);
            chk("t2_release", key_release, (k == 7) ? 1 : 0);
        end

        // 3: bounce low 3, high 1, then low steady
        presses = 0;
        for (int k = 1; k <= 14; k++) begin
            key_in = (k == 4) ? 1'b1 : 1'b0;
            tick();
            if (key_press) presses++;
            chk("t3_press", key_press, (k == 11) ? 1 : 0);
            chk("t3_level", key_level, (k >= 11) ? 1 : 0);
        end
        chk("t3_press_count", presses, 1);
        key_in = 1'b1;
        repeat (10) tick();

        // 4: glitches of 1, 2, 3 cycles never qualify
        for (int g = 1; g <= 3; g++) begin
            for (int k = 1; k <= g + 8; k++) begin
                key_in = (k <= g) ? 1'b0 : 1'b1;
                tick();
                chk("t4_level", key_level, 0);
                chk("t4_press", key_press, 0);
            end
        end

        // 5: reset lands mid-filter with the key held
        key_in = 1'b0;
        repeat (5) tick();
        chk("t5_prereset_level", key_level, 0);
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("t5_inreset_level", key_level, 0);
            chk("t5_inreset_press", key_press, 0);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("t5_press", key_press, (k == 7) ? 1 : 0);
            chk("t5_level", key_level, (k >= 7) ? 1 : 0);
        end
        key_in = 1'b1;
        repeat (10) tick();

        // 6: long hold
        key_in = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            tick();
`ifdef KEY_LONGPRESS_EN
            chk("t6_long", key_long, (k == 15) ? 1 : 0);
`else
            chk("t6_long_off", key_long, 0);
`endif
        end
        key_in = 1'b1;
        repeat (10) tick();

        // randomized activity: bouncy edges, long holds, occasional reset
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 29) == 0) begin
                rst_n = 1'b0;
                repeat ($urandom_range(1, 2)) tick();
                rst_n = 1'b1;
            end
            key_in = $urandom_range(0, 1) ? 1'b1 : 1'b0;
            hold = ($urandom_range(0, 9) < 7) ? $urandom_range(1, 6) : $urandom_range(6, 25);
            repeat (hold) tick();
        end
        key_in = 1'b1;
        repeat (12) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
